fft_job_arbiter: RTL and testbench

Round-robin job arbiter that shares one FFT core between two frame sources. Grants the core to one source per job and passes that source's input frame of 2^N beats through to the core. Routes the core's output frame of 2^N beats back to the same source, then releases the core. Sits between the two source/sink stream interfaces and the core's `in_vld`/`in_rdy`/`out_vld`/`out_rdy` handshake.

---
 rtl/fft_job_arbiter_if.sv | 54 +++++
 rtl/fft_job_arbiter.sv | 128 ++++++++++++
 tb/tb_fft_job_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_job_arbiter_if.sv
// rtl/fft_job_arbiter_if.sv - bundle of source/sink streams, core handshake and status for fft_job_arbiter
//
// Purpose: carries every non-clock/reset signal of fft_job_arbiter.
//   master modport: environment side (two frame sources/sinks and the FFT core).
//   slave modport : arbiter side.
// Signals:
//   s0/s1_in_vld, s0/s1_in_data  source k input beat  (master -> slave)
//   s0/s1_in_rdy                 beat accepted        (slave -> master)
//   s0/s1_out_vld, out_data      result beat to sink  (slave -> master)
//   s0/s1_out_rdy                sink accepts result  (master -> slave)
//   core_in_vld/rdy/data         core input handshake
//   core_out_vld/rdy/data        core output handshake
//   busy, owner, done, err       job status
interface fft_job_arbiter_if;
  logic        s0_in_vld;
  logic        s1_in_vld;
  logic        s0_in_rdy;
  logic        s1_in_rdy;
  logic [63:0] s0_in_data;
  logic [63:0] s1_in_data;
  logic        s0_out_vld;
  logic        s1_out_vld;
  logic        s0_out_rdy;
  logic        s1_out_rdy;
  logic [63:0] out_data;
  logic        core_in_vld;
  logic        core_in_rdy;
  logic [63:0] core_in_data;
  logic        core_out_vld;
  logic        core_out_rdy;
  logic [63:0] core_out_data;
  logic        busy;
  logic        owner;
  logic        done;
  logic        err;

  modport master (
    output s0_in_vld, s1_in_vld, s0_in_data, s1_in_data,
    output s0_out_rdy, s1_out_rdy,
    output core_in_rdy, core_out_vld, core_out_data,
    input  s0_in_rdy, s1_in_rdy, s0_out_vld, s1_out_vld, out_data,
    input  core_in_vld, core_in_data, core_out_rdy,
    input  busy, owner, done, err
  );

  modport slave (
    input  s0_in_vld, s1_in_vld, s0_in_data, s1_in_data,
    input  s0_out_rdy, s1_out_rdy,
    input  core_in_rdy, core_out_vld, core_out_data,
    output s0_in_rdy, s1_in_rdy, s0_out_vld, s1_out_vld, out_data,
    output core_in_vld, core_in_data, core_out_rdy,
    output busy, owner, done, err
  );
endinterface

// File: rtl/fft_job_arbiter.sv
// rtl/fft_job_arbiter.sv - round-robin arbiter sharing one FFT core between two frame sources
//
// Purpose: grants the core to one source per job, passes its 2^N-beat input
// frame through (LOAD), routes the 2^N-beat result frame back to the same
// source (DRAIN), then releases the core. Ties alternate between sources.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  fft_job_arbiter_if.slave (source/sink streams, core handshake, status)
// Parameter:
//   N    log2 of beats per frame (N >= 1)
module fft_job_arbiter #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  fft_job_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [N-1:0] CNT_LAST = '1;

  state_t       state;
  logic         owner_q;
  logic         last;
  logic [N-1:0] in_cnt;
  logic [N-1:0] out_cnt;
  logic         done_q;
  logic         err_q;

  logic         in_hs;
  logic         out_hs;

  // Handshake path is purely combinational; only the owner is ever connected.
  always_comb begin
    bus.s0_in_rdy    = 1'b0;
    bus.s1_in_rdy    = 1'b0;
    bus.core_in_vld  = 1'b0;
    bus.s0_out_vld   = 1'b0;
    bus.s1_out_vld   = 1'b0;
    bus.core_out_rdy = 1'b0;
    bus.core_in_data = owner_q ? bus.s1_in_data : bus.s0_in_data;
    bus.out_data     = bus.core_out_data;
    case (state)
      LOAD: begin
        if (owner_q) begin
          bus.core_in_vld = bus.s1_in_vld;
          bus.s1_in_rdy   = bus.core_in_rdy;
        end else begin
          bus.core_in_vld = bus.s0_in_vld;
          bus.s0_in_rdy   = bus.core_in_rdy;
        end
      end
      DRAIN: begin
        if (owner_q) begin
          bus.s1_out_vld   = bus.core_out_vld;
          bus.core_out_rdy = bus.s1_out_rdy;
        end else begin
          bus.s0_out_vld   = bus.core_out_vld;
          bus.core_out_rdy = bus.s0_out_rdy;
        end
      end
      default: begin
      end
    endcase
  end

  assign in_hs  = bus.core_in_vld & bus.core_in_rdy;
  assign out_hs = bus.core_out_vld & bus.core_out_rdy;

  assign bus.busy  = (state != IDLE);
  assign bus.owner = owner_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      last    <= 1'b1;    // s0 wins the first tie after reset
      in_cnt  <= '0;
      out_cnt <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Core output outside DRAIN is never consumed; it only flags the error.
      if (bus.core_out_vld && (state != DRAIN)) begin
        err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.s0_in_vld || bus.s1_in_vld) begin
            owner_q <= (bus.s0_in_vld && bus.s1_in_vld) ? ~last : bus.s1_in_vld;
            state   <= LOAD;
            in_cnt  <= '0;
          end
        end
        LOAD: begin
          if (in_hs) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == CNT_LAST) begin
              state   <= DRAIN;
              out_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == CNT_LAST) begin
              state  <= IDLE;
              last   <= owner_q;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_job_arbiter.sv
// tb/tb_fft_job_arbiter.sv - directed self-checking bench for fft_job_arbiter (N=2)
module tb_fft_job_arbiter;
  localparam int N     = 2;
  localparam int BEATS = 1 << N;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  fft_job_arbiter_if bus ();

  fft_job_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] src_word(input int src, input int beat);
    return {32'(src + 1), 32'(beat) + 32'h0000_A000};
  endfunction

  // One full job at full throughput; starts in an IDLE cycle, ends in the done cycle.
  task automatic do_job(input logic r0, input logic r1, input logic exp_own, input string tag);
    bus.s0_in_vld    = r0;
    bus.s1_in_vld    = r1;
    bus.core_in_rdy  = 1'b1;
    bus.core_out_vld = 1'b0;
    bus.s0_out_rdy   = 1'b1;
    bus.s1_out_rdy   = 1'b1;
    #1;
    chk({tag, ".idle_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ".idle_core_in_vld"}, 64'(bus.core_in_vld), 64'd0);
    step();
    chk({tag, ".owner"}, 64'(bus.owner), 64'(exp_own));
    chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
    for (int b = 0; b < BEATS; b++) begin
      bus.s0_in_data = src_word(0, b);
      bus.s1_in_data = src_word(1, b);
      #1;
      chk({tag, ".core_in_vld"}, 64'(bus.core_in_vld), 64'd1);
      chk({tag, ".core_in_data"}, bus.core_in_data, src_word(exp_own ? 1 : 0, b));
      chk({tag, ".own_in_rdy"}, 64'(exp_own ? bus.s1_in_rdy : bus.s0_in_rdy), 64'd1);
      chk({tag, ".oth_in_rdy"}, 64'(exp_own ? bus.s0_in_rdy : bus.s1_in_rdy), 64'd0);
      step();
    end
    for (int b = 0; b < BEATS; b++) begin
      bus.core_out_vld  = 1'b1;
      bus.core_out_data = 64'hD000_0000_0000_0000 | 64'(b);
      #1;
      chk({tag, ".drain_in_rdy"}, 64'(bus.s0_in_rdy | bus.s1_in_rdy), 64'd0);
      chk({tag, ".own_out_vld"}, 64'(exp_own ? bus.s1_out_vld : bus.s0_out_vld), 64'd1);
      chk({tag, ".oth_out_vld"}, 64'(exp_own ? bus.s0_out_vld : bus.s1_out_vld), 64'd0);
      chk({tag, ".out_data"}, bus.out_data, 64'hD000_0000_0000_0000 | 64'(b));
      chk({tag, ".done_early"}, 64'(bus.done), 64'd0);
      step();
    end
    bus.core_out_vld = 1'b0;
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [6:0] in_rdy_pat;
    logic [6:0] out_rdy_pat;
    int         hs;

    n_total = 0;
    n_pass  = 0;
    rst               = 1'b1;
    bus.s0_in_vld     = 1'b0;
    bus.s1_in_vld     = 1'b0;
    bus.s0_in_data    = 64'h0123_4567_89AB_CDEF;
    bus.s1_in_data    = 64'hFEDC_BA98_7654_3210;
    bus.s0_out_rdy    = 1'b0;
    bus.s1_out_rdy    = 1'b0;
    bus.core_in_rdy   = 1'b0;
    bus.core_out_vld  = 1'b0;
    bus.core_out_data = 64'h1111_2222_3333_4444;
    step();
    step();

    // Reset state
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.owner", 64'(bus.owner), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.err", 64'(bus.err), 64'd0);
    chk("rst.rdy_vld", {58'd0, bus.s0_in_rdy, bus.s1_in_rdy, bus.s0_out_vld,
                        bus.s1_out_vld, bus.core_in_vld, bus.core_out_rdy}, 64'd0);
    chk("rst.core_in_data", bus.core_in_data, 64'h0123_4567_89AB_CDEF);
    chk("rst.out_data", bus.out_data, 64'h1111_2222_3333_4444);
    rst = 1'b0;

    // Single s0 job; no beat taken in IDLE, s1 side stays quiet
    bus.s0_in_vld   = 1'b1;
    bus.core_in_rdy = 1'b1;
    #1;
    chk("single.idle_s0_in_rdy", 64'(bus.s0_in_rdy), 64'd0);
    do_job(1'b1, 1'b0, 1'b0, "single");
    bus.s0_in_vld = 1'b0;
    step();
    chk("single.done_clear", 64'(bus.done), 64'd0);
    chk("single.err", 64'(bus.err), 64'd0);

    // Contention from a fresh reset: 0, 1, 0 with one IDLE cycle between jobs
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_job(1'b1, 1'b1, 1'b0, "cont0");
    do_job(1'b1, 1'b1, 1'b1, "cont1");
    do_job(1'b1, 1'b1, 1'b0, "cont2");
    bus.s0_in_vld = 1'b0;
    bus.s1_in_vld = 1'b0;
    step();

    // Backpressure on s1: core_in_rdy 1,0,1,0,1,0,1 gives 4 handshakes over 7 cycles
    bus.s1_in_vld = 1'b1;
    step();
    chk("bp.owner", 64'(bus.owner), 64'd1);
    in_rdy_pat = 7'b1010101;
    for (int c = 0; c < 7; c++) begin
      bus.core_in_rdy = in_rdy_pat[6-c];
      #1;
      chk("bp.load_busy", 64'(bus.busy), 64'd1);
      chk("bp.s1_in_rdy", 64'(bus.s1_in_rdy), 64'(in_rdy_pat[6-c]));
      step();
    end
    // Now in DRAIN: input side closed even though core is ready
    bus.core_in_rdy = 1'b1;
    #1;
    chk("bp.drain_s1_in_rdy", 64'(bus.s1_in_rdy), 64'd0);
    chk("bp.drain_core_in_vld", 64'(bus.core_in_vld), 64'd0);
    bus.s1_in_vld = 1'b0;
    // Sink pattern 1,0,0,0,1,1,1 gives 4 handshakes; done only after the 4th
    out_rdy_pat = 7'b1000111;
    hs = 0;
    for (int c = 0; c < 7; c++) begin
      bus.core_out_vld = 1'b1;
      bus.s1_out_rdy   = out_rdy_pat[6-c];
      #1;
      chk("bp.core_out_rdy", 64'(bus.core_out_rdy), 64'(out_rdy_pat[6-c]));
      chk("bp.s1_out_vld", 64'(bus.s1_out_vld), 64'd1);
      if (out_rdy_pat[6-c]) hs++;
      step();
      chk("bp.done", 64'(bus.done), 64'(hs == BEATS));
      chk("bp.busy", 64'(bus.busy), 64'(hs != BEATS));
    end
    bus.core_out_vld = 1'b0;

    // Protocol error in IDLE: not consumed, sticky through a full job
    step();
    bus.core_out_vld = 1'b1;
    #1;
    chk("err.core_out_rdy", 64'(bus.core_out_rdy), 64'd0);
    step();
    bus.core_out_vld = 1'b0;
    chk("err.set", 64'(bus.err), 64'd1);
    chk("err.busy", 64'(bus.busy), 64'd0);
    do_job(1'b1, 1'b0, 1'b0, "errjob");
    chk("err.sticky", 64'(bus.err), 64'd1);
    bus.s0_in_vld = 1'b0;
    step();

    // Reset mid-LOAD: last was s0, so the tie goes to s1 before reset and to s0 after
    bus.s0_in_vld   = 1'b1;
    bus.s1_in_vld   = 1'b1;
    bus.core_in_rdy = 1'b1;
    step();
    chk("mid.owner_pre", 64'(bus.owner), 64'd1);
    step();
    step();
    rst = 1'b1;
    step();
    #1;
    chk("mid.busy", 64'(bus.busy), 64'd0);
    chk("mid.owner", 64'(bus.owner), 64'd0);
    chk("mid.err", 64'(bus.err), 64'd0);
    chk("mid.rdy_vld", {58'd0, bus.s0_in_rdy, bus.s1_in_rdy, bus.s0_out_vld,
                        bus.s1_out_vld, bus.core_in_vld, bus.core_out_rdy}, 64'd0);
    rst = 1'b0;
    step();
    chk("mid.regrant_owner", 64'(bus.owner), 64'd0);
    chk("mid.regrant_busy", 64'(bus.busy), 64'd1);
    bus.s0_in_vld = 1'b0;
    bus.s1_in_vld = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
